fsm_code_monitor: RTL

Checker that sits on the consumer end of the 3-bit state-code output of our small control FSMs. It decodes each sampled code, enforces the legal code set and transition graph, times how long each non-idle state persists, and latches a sticky fault with a cause code. Every accepted transition is logged into a small history FIFO that firmware or a debug port can read. The block is the receiver and policer for the FSM's `out` bus and never drives the FSM itself.

---
 rtl/fsm_code_monitor.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/fsm_code_monitor.sv
// Consumer-side checker for a 3-bit FSM state-code bus. It polices the legal
// code set, the transition graph and per-state dwell time, latches a sticky
// fault with a cause code, and logs every accepted transition in a small FIFO.
module fsm_code_monitor #(
    parameter int unsigned DWELL_MAX  = 15,
    parameter int unsigned CNT_W      = 4,
    parameter int unsigned HIST_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       code_in,
    input  logic             code_valid,
    input  logic             clear_fault,
    output logic             fault,
    output logic [1:0]       fault_cause,
    output logic [1:0]       cur_state,
    output logic             trans_pulse,
    output logic [CNT_W-1:0] dwell_cnt,
    input  logic             hist_rd_en,
    output logic [3:0]       hist_data,
    output logic             hist_empty,
    output logic             hist_full,
    output logic             hist_ovf
);

    localparam int unsigned PTR_W = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;
    localparam int unsigned HCW   = PTR_W + 1;
    localparam logic [HCW-1:0]   FullCount = HCW'(HIST_DEPTH);
    localparam logic [CNT_W-1:0] DwellLim  = CNT_W'(DWELL_MAX);

    localparam logic [1:0] CauseNone  = 2'b00;
    localparam logic [1:0] CauseCode  = 2'b01;
    localparam logic [1:0] CauseTrans = 2'b10;
    localparam logic [1:0] CauseDwell = 2'b11;

    typedef enum logic [1:0] {StIdle, StTrack, StFault} state_e;

    state_e           state_q, state_d;
    logic             fault_q, fault_d;
    logic [1:0]       cause_q, cause_d;
    logic [1:0]       cur_q, cur_d;
    logic             pulse_q, pulse_d;
    logic [CNT_W-1:0] dwell_q, dwell_d;

    logic [3:0]       mem_q [HIST_DEPTH];
    logic [3:0]       mem_d [HIST_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [HCW-1:0]   count_q, count_d;
    logic             ovf_q, ovf_d;

    logic             code_ill, is_hold, trans_ok, dwell_hit, push;
    logic [CNT_W-1:0] dwell_inc;
    logic [3:0]       push_data;

    // Decode the incoming sample against the last accepted code.
    always_comb begin
        code_ill  = code_in[2];
        is_hold   = (code_in[1:0] == cur_q);
        // Forward step by one, back to 0, or hold; 3 has no successor but 0.
        trans_ok  = is_hold || (code_in[1:0] == 2'd0) ||
                    ((cur_q != 2'd3) && (code_in[1:0] == cur_q + 2'd1));
        dwell_inc = dwell_q + CNT_W'(1);
        dwell_hit = (dwell_inc == DwellLim);
    end

    // Monitor state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // Next monitor state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (code_valid) state_d = code_ill ? StFault : StTrack;
            end
            StTrack: begin
                if (code_valid && (code_ill || !trans_ok ||
                    (is_hold && (code_in[1:0] != 2'd0) && dwell_hit))) begin
                    state_d = StFault;
                end
            end
            StFault: begin
                if (clear_fault) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Next values of the registered outputs and the FIFO push request.
    always_comb begin
        fault_d   = fault_q;
        cause_d   = cause_q;
        cur_d     = cur_q;
        pulse_d   = 1'b0;
        dwell_d   = dwell_q;
        push      = 1'b0;
        push_data = {cur_q, code_in[1:0]};
        unique case (state_q)
            StIdle: begin
                if (code_valid) begin
                    if (code_ill) begin
                        fault_d = 1'b1;
                        cause_d = CauseCode;
                    end else begin
                        cur_d   = code_in[1:0];
                        dwell_d = '0;
                    end
                end
            end
            StTrack: begin
                if (code_valid) begin
                    if (code_ill) begin
                        fault_d = 1'b1;
                        cause_d = CauseCode;
                    end else if (!trans_ok) begin
                        fault_d = 1'b1;
                        cause_d = CauseTrans;
                    end else if (is_hold) begin
                        if (code_in[1:0] != 2'd0) begin
                            // Counter shows DWELL_MAX on the timeout, then freezes in FAULT.
                            dwell_d = dwell_inc;
                            if (dwell_hit) begin
                                fault_d = 1'b1;
                                cause_d = CauseDwell;
                            end
                        end
                    end else begin
                        cur_d   = code_in[1:0];
                        pulse_d = 1'b1;
                        push    = 1'b1;
                        dwell_d = (code_in[1:0] == 2'd0) ? '0 : CNT_W'(1);
                    end
                end
            end
            StFault: begin
                if (clear_fault) begin
                    fault_d = 1'b0;
                    cause_d = CauseNone;
                    dwell_d = '0;
                end
            end
            default: ;
        endcase
    end

    // Registered monitor outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_q <= 1'b0;
            cause_q <= CauseNone;
            cur_q   <= 2'd0;
            pulse_q <= 1'b0;
            dwell_q <= '0;
        end else begin
            fault_q <= fault_d;
            cause_q <= cause_d;
            cur_q   <= cur_d;
            pulse_q <= pulse_d;
            dwell_q <= dwell_d;
        end
    end

    // History FIFO next state; a pop frees the slot a same-cycle push needs.
    always_comb begin
        logic do_pop, do_push;
        do_pop   = hist_rd_en && (count_q != '0);
        do_push  = push && ((count_q != FullCount) || do_pop);
        ovf_d    = ovf_q | (push && !do_push);
        mem_d    = mem_q;
        if (do_push) mem_d[wr_ptr_q] = push_data;
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q + HCW'(do_push) - HCW'(do_pop);
    end

    // History FIFO storage and pointers; contents are discarded on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(HIST_DEPTH); i++) mem_q[i] <= 4'd0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Output mapping; the FIFO head reads 0 while empty.
    always_comb begin
        fault       = fault_q;
        fault_cause = cause_q;
        cur_state   = cur_q;
        trans_pulse = pulse_q;
        dwell_cnt   = dwell_q;
        hist_empty  = (count_q == '0);
        hist_full   = (count_q == FullCount);
        hist_ovf    = ovf_q;
        hist_data   = hist_empty ? 4'd0 : mem_q[rd_ptr_q];
    end

endmodule
